// File: rtl/pe_cache_responder.sv
`default_nettype none
// ==========================================================================
// pe_cache_responder: direct-mapped, write-through, no-write-allocate cache
// responder between the PE memory port and a req/ack backing memory.
// Revision: 1.0
// ==========================================================================
module pe_cache_responder #(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_ADDR_WIDTH = 16,
  parameter int LINE_BITS        = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        CACHE_VALID_I,
  input  logic                        CACHE_WR_I,
  input  logic [CACHE_ADDR_WIDTH-1:0] CACHE_ADDR_I,
  input  logic [DATA_WIDTH-1:0]       CACHE_DATA_I,
  output logic [DATA_WIDTH-1:0]       CACHE_DATA_O,
  output logic                        STALL_O,
  input  logic                        INVALIDATE_I,
  output logic                        MEM_REQ_O,
  output logic                        MEM_WR_O,
  output logic [CACHE_ADDR_WIDTH-1:0] MEM_ADDR_O,
  output logic [DATA_WIDTH-1:0]       MEM_DATA_O,
  input  logic                        MEM_ACK_I,
  input  logic [DATA_WIDTH-1:0]       MEM_DATA_I,
  output logic [CNT_WIDTH-1:0]        HIT_CNT_O,
  output logic [CNT_WIDTH-1:0]        MISS_CNT_O
);
  localparam int LINES     = 1 << LINE_BITS;
  localparam int TAG_WIDTH = CACHE_ADDR_WIDTH - LINE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [LINES-1:0]            valid_q, valid_d;
  logic                        inv_pend_q, inv_pend_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [CACHE_ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]       mdata_q, mdata_d;
  logic [CNT_WIDTH-1:0]        hit_q, hit_d, miss_q, miss_d;
  logic [TAG_WIDTH-1:0]        tag_q  [LINES];
  logic [DATA_WIDTH-1:0]       line_q [LINES];

  logic                        line_we;
  logic [LINE_BITS-1:0]        line_idx;
  logic [TAG_WIDTH-1:0]        line_tag;
  logic [DATA_WIDTH-1:0]       line_wdata;

  logic [LINE_BITS-1:0]        req_idx, fill_idx;
  logic [TAG_WIDTH-1:0]        req_tag, fill_tag;
  logic                        req_hit;

  assign req_idx  = CACHE_ADDR_I[LINE_BITS-1:0];
  assign req_tag  = CACHE_ADDR_I[CACHE_ADDR_WIDTH-1:LINE_BITS];
  assign fill_idx = maddr_q[LINE_BITS-1:0];
  assign fill_tag = maddr_q[CACHE_ADDR_WIDTH-1:LINE_BITS];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    inv_pend_d = inv_pend_q;
    rdata_d    = rdata_q;
    maddr_d    = maddr_q;
    mdata_d    = mdata_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    line_we    = 1'b0;
    line_idx   = req_idx;
    line_tag   = req_tag;
    line_wdata = CACHE_DATA_I;
    case (state_q)
      ST_IDLE: begin
        if (CACHE_VALID_I) begin
          if (CACHE_WR_I) begin
            state_d = ST_WRITE;
            maddr_d = CACHE_ADDR_I;
            mdata_d = CACHE_DATA_I;
            line_we = req_hit;
          end else if (req_hit) begin
            rdata_d = line_q[req_idx];
            if (hit_q != '1) hit_d = hit_q + 1'b1;
          end else begin
            state_d = ST_FILL;
            maddr_d = CACHE_ADDR_I;
            if (miss_q != '1) miss_d = miss_q + 1'b1;
          end
        end
        // Request above was judged on the pre-invalidate valid bits.
        if (INVALIDATE_I) valid_d = '0;
      end
      ST_FILL, ST_WRITE: begin
        if (INVALIDATE_I) inv_pend_d = 1'b1;
        if (MEM_ACK_I) begin
          state_d = ST_IDLE;
          if (state_q == ST_FILL) begin
            line_we           = 1'b1;
            line_idx          = fill_idx;
            line_tag          = fill_tag;
            line_wdata        = MEM_DATA_I;
            valid_d[fill_idx] = 1'b1;
            rdata_d           = MEM_DATA_I;
          end
          if (inv_pend_q || INVALIDATE_I) valid_d = '0;
          inv_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      inv_pend_q <= 1'b0;
      rdata_q    <= '0;
      maddr_q    <= '0;
      mdata_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      inv_pend_q <= inv_pend_d;
      rdata_q    <= rdata_d;
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge CLK_I) begin
    if (line_we) begin
      line_q[line_idx] <= line_wdata;
      tag_q[line_idx]  <= line_tag;
    end
  end

  assign STALL_O      = (state_q != ST_IDLE);
  assign MEM_REQ_O    = (state_q != ST_IDLE);
  assign MEM_WR_O     = (state_q == ST_WRITE);
  assign MEM_ADDR_O   = maddr_q;
  assign MEM_DATA_O   = mdata_q;
  assign CACHE_DATA_O = rdata_q;
  assign HIT_CNT_O    = hit_q;
  assign MISS_CNT_O   = miss_q;
endmodule
`default_nettype wire
